// File: rtl/cache_write_buffer_if.sv
// Bus bundle for the posted-write buffer: cache store port, refill lookup port and memory drain port.
// The slave modport is the buffer; the master modport is the cache/memory environment.
interface cache_write_buffer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_fwd_hit;
   logic [DATA_W-1:0] rd_fwd_data;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ack;

   modport slave (
      input  wr_valid, wr_addr, wr_data, rd_addr, mem_ack,
      output wr_ready, rd_fwd_hit, rd_fwd_data, mem_req, mem_addr, mem_data
   );

   modport master (
      output wr_valid, wr_addr, wr_data, rd_addr, mem_ack,
      input  wr_ready, rd_fwd_hit, rd_fwd_data, mem_req, mem_addr, mem_data
   );
endinterface

// File: rtl/cache_write_buffer.sv
// Posted-write FIFO between the write-through cache and memory, with refill forwarding.
// Define WRITE_BUFFER_MERGE_EN to merge stores into an existing entry of the same word address.
module cache_write_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   cache_write_buffer_if.slave      bus,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int WW = ADDR_W - 2;

   typedef enum logic [1:0] {IDLE, ISSUE, RETIRE} state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [WW-1:0]     addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   logic              push, alloc, pop;
   logic              merge_hit;
   logic [PW-1:0]     merge_idx;
   logic [WW-1:0]     wr_word, rd_word;
   logic              unused_addr_lsbs;

   assign wr_word          = bus.wr_addr[ADDR_W-1:2];
   assign rd_word          = bus.rd_addr[ADDR_W-1:2];
   assign unused_addr_lsbs = ^{bus.wr_addr[1:0], bus.rd_addr[1:0]};

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;

`ifdef WRITE_BUFFER_MERGE_EN
   // The head is locked while it is on the memory bus, so a store to it must allocate.
   always_comb begin
      merge_hit = 1'b0;
      merge_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count_q && !(i == 0 && state_q == ISSUE) &&
             addr_q[rd_ptr_q + PW'(i)] == wr_word) begin
            merge_hit = 1'b1;
            merge_idx = rd_ptr_q + PW'(i);
         end
      end
   end
`else
   assign merge_hit = 1'b0;
   assign merge_idx = '0;
`endif

   assign bus.wr_ready = !full || merge_hit;
   assign push         = bus.wr_valid && bus.wr_ready;
   assign alloc        = push && !merge_hit;

   // Scan oldest to youngest so the youngest matching entry wins.
   always_comb begin
      bus.rd_fwd_hit  = 1'b0;
      bus.rd_fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count_q && addr_q[rd_ptr_q + PW'(i)] == rd_word) begin
            bus.rd_fwd_hit  = 1'b1;
            bus.rd_fwd_data = data_q[rd_ptr_q + PW'(i)];
         end
      end
   end

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE:    if (!empty) state_d = ISSUE;
         ISSUE:   if (bus.mem_ack) begin
                     pop     = 1'b1;
                     state_d = RETIRE;
                  end
         RETIRE:  state_d = empty ? IDLE : ISSUE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.mem_req  = (state_q == ISSUE);
   assign bus.mem_addr = bus.mem_req ? {addr_q[rd_ptr_q], 2'b00} : '0;
   assign bus.mem_data = bus.mem_req ? data_q[rd_ptr_q] : '0;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(alloc);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(alloc) - CW'(pop);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the entry array is not reset; count_q decides validity and the memory outputs are gated.
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[alloc ? wr_ptr_q : merge_idx] <= bus.wr_data;
         if (alloc) addr_q[wr_ptr_q] <= wr_word;
      end
   end
endmodule
